hack_cpu_mc: RTL and testbench
==============================

# hack_cpu_mc

Parametrised multi-cycle successor to the single-cycle Hack CPU. It executes the Hack A/C instruction set at a configurable data and address width. Instruction fetch and data memory are reached through request/ready handshakes, so the core tolerates wait-stated ROM and RAM. It sits between the instruction ROM and data RAM/MMIO bus of the Hack computer top level.

## Interface
- WIDTH, 16, datapath width (D, A, ALU, instruction, memory data); must be ≥16
- ADDR_W, 15, width of pc, instruction address and data address; must be ≤ WIDTH-1
- clock  in  1  main clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- instr_req  out  1  fetch request; instr_addr is valid while high
- instr_addr  out  ADDR_W  fetch address (= pc)
- instr_valid  in  1  instruction word present this cycle; ignored while instr_req low
- instruction  in  WIDTH  fetched instruction word
- mem_re  out  1  data read request
- mem_we  out  1  data write request
- mem_addr  out  ADDR_W  data address = A[ADDR_W-1:0] captured at decode
- mem_wdata  out  WIDTH  write data (latched ALU result)
- mem_ready  in  1  completes the current mem_re/mem_we transfer
- mem_rdata  in  WIDTH  read data, sampled when mem_ready is high during a read
- pc  out  ADDR_W  program counter
- halted  out  1  core parked in HALT (see Configuration)

## Operation
- Decode: IR[WIDTH-1]=0 is an A-instruction; A <= IR with its MSB cleared. IR[WIDTH-1]=1 is a C-instruction with a=IR[12], zx/nx/zy/ny/f/no=IR[11:6], dest A/D/M=IR[5:3], jump j1/j2/j3=IR[2:0]. IR[WIDTH-2:13] are ignored.
- ALU: standard Hack function at WIDTH bits. Flags: zr = (out==0); ng = out[WIDTH-1]. y = M when a=1, otherwise y = A.
- Jump taken = (j1&ng) | (j2&zr) | (j3&~zr&~ng). Target = A value before this instruction's A write.
- States: FETCH, MREAD, EXEC, MWRITE, HALT.
- FETCH: instr_req=1. On instr_valid, latch IR. Go to MREAD if C with a=1, otherwise go to EXEC.
- MREAD: mem_re=1, mem_addr=A. On mem_ready, latch M=mem_rdata and go to EXEC.
- EXEC: compute ALU. Commit D and A if selected. pc <= taken ? A_old : pc+1. Latch wdata and address (A_old).
- EXEC exit: MWRITE if dest M is set, otherwise FETCH.
- MWRITE: mem_we=1 with the latched address and data. On mem_ready, go to FETCH.
- mem_addr and mem_wdata always use the pre-update A, including for AM= and AMD= destinations.
- pc wraps from 2^ADDR_W-1 to 0. A and ALU results wrap mod 2^WIDTH.
- mem_re and mem_we are never high together. Neither is ever high together with instr_req.

## Timing
- Reset values: pc=0, A=0, D=0, IR=0, state=FETCH. instr_req, mem_re, mem_we, halted = 0 during the reset cycle. instr_addr, mem_addr, mem_wdata = 0.
- The first instr_req goes high in the cycle after reset deasserts.
- Request outputs are decoded from state. Address and data stay stable from request assertion until the ready/valid edge.
- A transfer completes on the rising edge where the request and ready/valid are both high. Stalls of any length are allowed.
- Zero-wait cycle counts:
  - A-instruction: 2 cycles
  - C-instruction with no M access: 2 cycles
  - C-instruction with M read: 3 cycles
  - C-instruction with M write: +1 cycle
- Reset asserted in any state, including mid-stall, returns to FETCH on that edge. The pending transfer is abandoned, no register commits, and requests drop in the next cycle.

## Configuration
- HACK_CPU_HALT_DETECT_EN defined:
  - In EXEC, a taken jump whose target equals the current pc enters HALT instead of FETCH. Register and pc commits still occur.
  - In HALT: halted=1 and no requests are issued. Only reset exits HALT.
- Undefined: halted is tied to 0. Self-loops execute indefinitely through FETCH.

## Test plan
- Reset then release with instr_valid=1 → first cycle: instr_req=1, instr_addr=0, mem_re=mem_we=0, halted=0.
- ROM: @5 then D=A (0xEC10), zero wait → after 4 cycles: D=5, A=5, pc=2.
- @100 then D=M with mem_ready delayed 3 cycles, mem_rdata=0x1234 → mem_re held 4 cycles at mem_addr=100, then D=0x1234, pc=2.
- D=5, @100, AM=D+1 → A=6, and mem_we held through a 2-cycle stall with mem_addr=100, mem_wdata=6. Reset asserted mid-stall → mem_we=0 next cycle, pc=0.
- Branch cases, with @10:
  - D=0, D;JEQ → pc=10.
  - D=0, D;JGT → pc advances by 1.
  - D=-1 (0xFFFF), D;JLT → pc=10.
  - WIDTH=32 build: D=0x8000_0000, D;JLT → taken.
- Instruction `0;JMP` at pc=3 with A=3 → macro defined: halted=1 and instr_req stays 0. Macro undefined: pc stays 3 and the instruction is refetched every 2 cycles.

Source files
------------

// File: rtl/hack_cpu_mc.sv
// Multi-cycle Hack CPU with request/ready fetch and data-memory handshakes.
// Optional self-loop halt detection is enabled by defining HACK_CPU_HALT_DETECT_EN.
module hack_cpu_mc #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 15
) (
  input  logic              clock,
  input  logic              reset,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [WIDTH-1:0]  instruction,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ready,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_MREAD  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MWRITE = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, maddr_q, maddr_d;
  logic [WIDTH-1:0]  a_q, a_d, d_q, d_d, ir_q, ir_d, m_q, m_d, wdata_q, wdata_d;
  logic [WIDTH-1:0]  alu_out;
  logic [ADDR_W-1:0] pc_inc;
  logic              is_c, zr, ng, taken;

  function automatic logic [WIDTH-1:0] hack_alu(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [5:0]       c);
    logic [WIDTH-1:0] xs, ys, r;
    xs = c[5] ? '0 : x;
    if (c[4]) xs = ~xs;
    ys = c[3] ? '0 : y;
    if (c[2]) ys = ~ys;
    r = c[1] ? (xs + ys) : (xs & ys);
    if (c[0]) r = ~r;
    return r;
  endfunction

  assign is_c    = ir_q[WIDTH-1];
  assign alu_out = hack_alu(d_q, ir_q[12] ? m_q : a_q, ir_q[11:6]);
  assign zr      = (alu_out == '0);
  assign ng      = alu_out[WIDTH-1];
  assign taken   = is_c & ((ir_q[2] & ng) | (ir_q[1] & zr) | (ir_q[0] & ~zr & ~ng));
  assign pc_inc  = pc_q + ADDR_W'(1);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    a_d     = a_q;
    d_d     = d_q;
    ir_d    = ir_q;
    m_d     = m_q;
    wdata_d = wdata_q;
    maddr_d = maddr_q;
    case (state_q)
      S_FETCH: begin
        if (instr_valid) begin
          ir_d    = instruction;
          maddr_d = a_q[ADDR_W-1:0];
          state_d = (instruction[WIDTH-1] && instruction[12]) ? S_MREAD : S_EXEC;
        end
      end
      S_MREAD: begin
        if (mem_ready) begin
          m_d     = mem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!is_c) begin
          a_d     = {1'b0, ir_q[WIDTH-2:0]};
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end else begin
          if (ir_q[5]) a_d = alu_out;
          if (ir_q[4]) d_d = alu_out;
          // Address and target both come from the A value before this commit.
          wdata_d = alu_out;
          maddr_d = a_q[ADDR_W-1:0];
          pc_d    = taken ? a_q[ADDR_W-1:0] : pc_inc;
          if (ir_q[3]) state_d = S_MWRITE;
`ifdef HACK_CPU_HALT_DETECT_EN
          else if (taken && (a_q[ADDR_W-1:0] == pc_q)) state_d = S_HALT;
`endif
          else state_d = S_FETCH;
        end
      end
      S_MWRITE: begin
        if (mem_ready) state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      ir_q    <= '0;
      m_q     <= '0;
      wdata_q <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      a_q     <= a_d;
      d_q     <= d_d;
      ir_q    <= ir_d;
      m_q     <= m_d;
      wdata_q <= wdata_d;
      maddr_q <= maddr_d;
    end
  end

  // Requests are pure state decodes, forced low while reset is held.
  assign instr_req  = ~reset & (state_q == S_FETCH);
  assign mem_re     = ~reset & (state_q == S_MREAD);
  assign mem_we     = ~reset & (state_q == S_MWRITE);
  assign instr_addr = pc_q;
  assign pc         = pc_q;
  assign mem_addr   = maddr_q;
  assign mem_wdata  = wdata_q;
`ifdef HACK_CPU_HALT_DETECT_EN
  assign halted     = ~reset & (state_q == S_HALT);
`else
  assign halted     = 1'b0;
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Bench for hack_cpu_mc: directed plan cases plus random programs against an instruction-level model.
module tb_hack_cpu_mc;
  localparam int W  = 16;
  localparam int AW = 15;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset = 1'b1, instr_valid = 1'b0, mem_ready = 1'b0;
  logic [W-1:0]  instruction = '0, mem_rdata = '0;
  logic          instr_req, mem_re, mem_we, halted;
  logic [AW-1:0] instr_addr, mem_addr, pc;
  logic [W-1:0]  mem_wdata;

  hack_cpu_mc #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instruction(instruction), .mem_re(mem_re), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .pc(pc), .halted(halted));

  // 32-bit instance driven by a zero-wait combinational ROM.
  logic          r32 = 1'b1;
  logic          ireq32, mre32, mwe32, halt32;
  logic [AW-1:0] iaddr32, maddr32, pc32;
  logic [31:0]   instr32, wdata32;
  logic [31:0]   rom32 [0:7];
  always_comb instr32 = rom32[iaddr32[2:0]];

  hack_cpu_mc #(.WIDTH(32), .ADDR_W(AW)) dut32 (
    .clock(clock), .reset(r32), .instr_req(ireq32), .instr_addr(iaddr32),
    .instr_valid(1'b1), .instruction(instr32), .mem_re(mre32), .mem_we(mwe32),
    .mem_addr(maddr32), .mem_wdata(wdata32), .mem_ready(1'b1), .mem_rdata(32'h0),
    .pc(pc32), .halted(halt32));

  int checks = 0, failures = 0, cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Instruction-level reference state
  logic [W-1:0]  a_m, d_m;
  logic [AW-1:0] pc_m;
  bit            halted_m, chain;
  int            t_prev, exp_dur, t_start;
  logic [W-1:0]  ram [int];

  localparam logic [5:0] C_ZERO = 6'b101010, C_NEG1 = 6'b111010, C_D = 6'b001100,
                         C_A = 6'b110000, C_DP1 = 6'b011111, C_DPA = 6'b000010;
  logic [5:0] comps [18] = '{6'b101010, 6'b111111, 6'b111010, 6'b001100, 6'b110000, 6'b001101,
                             6'b110001, 6'b001111, 6'b110011, 6'b011111, 6'b110111, 6'b001110,
                             6'b110010, 6'b000010, 6'b010011, 6'b000111, 6'b000000, 6'b010101};

  function automatic logic [W-1:0] cw(input logic a, input logic [5:0] c, input logic [2:0] d,
                                      input logic [2:0] j);
    return {3'b111, a, c, d, j};
  endfunction

  // Hack comp mnemonics evaluated directly
  function automatic logic [W-1:0] comp_val(input logic [5:0] c, input logic [W-1:0] x,
                                            input logic [W-1:0] y);
    case (c)
      6'b101010: return 0;       6'b111111: return 1;       6'b111010: return -1;
      6'b001100: return x;       6'b110000: return y;       6'b001101: return ~x;
      6'b110001: return ~y;      6'b001111: return -x;      6'b110011: return -y;
      6'b011111: return x + 1;   6'b110111: return y + 1;   6'b001110: return x - 1;
      6'b110010: return y - 1;   6'b000010: return x + y;   6'b010011: return x - y;
      6'b000111: return y - x;   6'b000000: return x & y;   6'b010101: return x | y;
      default:   return 'x;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return instr_req;
      1:       return mem_re;
      default: return mem_we;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag);
    int n = 0;
    while (sig(which) !== 1'b1 && n < 40) begin @(negedge clock); n++; end
    chk(tag, sig(which), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; mem_ready = 1'b0;
    @(negedge clock);
    chk("rst_instr_req", instr_req, 0); chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_we", mem_we, 0);       chk("rst_halted", halted, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("first_req", instr_req, 1);   chk("first_addr", instr_addr, 0);
    chk("first_pc", pc, 0);           chk("first_re", mem_re, 0);
    chk("first_we", mem_we, 0);       chk("first_halted", halted, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_wdata", mem_wdata, 0);
    chk("rst_A", dut.a_q, 0);         chk("rst_D", dut.d_q, 0);
    a_m = '0; d_m = '0; pc_m = '0; halted_m = 0; chain = 0;
    t_start = cyc;
  endtask

  task automatic do_fetch(input logic [W-1:0] word, input int wf);
    wait_for(0, "fetch_req");
    if (chain) chk("cycles", cyc - t_prev, exp_dur);
    t_prev = cyc;
    chk("fetch_addr", instr_addr, pc_m); chk("pc", pc, pc_m);
    chk("A", dut.a_q, a_m);              chk("D", dut.d_q, d_m);
    chk("fetch_excl", {mem_re, mem_we}, 0); chk("halted_run", halted, 0);
    for (int i = 0; i < wf; i++) begin
      instr_valid = 1'b0; instruction = W'($urandom);
      @(negedge clock);
      chk("fetch_hold", instr_req, 1); chk("fetch_stable", instr_addr, pc_m);
    end
    instr_valid = 1'b1; instruction = word;
    @(negedge clock);
    instr_valid = 1'b0; instruction = W'($urandom);
  endtask

  task automatic do_read(input int wm, input logic [W-1:0] rd);
    wait_for(1, "mread_req");
    chk("mread_addr", mem_addr, a_m[AW-1:0]); chk("mread_excl", {instr_req, mem_we}, 0);
    for (int i = 0; i < wm; i++) begin
      mem_rdata = W'($urandom);
      @(negedge clock);
      chk("mread_hold", mem_re, 1); chk("mread_stable", mem_addr, a_m[AW-1:0]);
    end
    mem_ready = 1'b1; mem_rdata = rd;
    @(negedge clock);
    mem_ready = 1'b0; mem_rdata = W'($urandom);
  endtask

  task automatic do_write(input int wm, input logic [AW-1:0] ad, input logic [W-1:0] dt);
    wait_for(2, "mwrite_req");
    chk("mwrite_addr", mem_addr, ad); chk("mwrite_data", mem_wdata, dt);
    chk("mwrite_excl", {instr_req, mem_re}, 0);
    for (int i = 0; i < wm; i++) begin
      @(negedge clock);
      chk("mwrite_hold", mem_we, 1); chk("mwrite_stable", {mem_addr, mem_wdata}, {ad, dt});
    end
    mem_ready = 1'b1;
    @(negedge clock);
    mem_ready = 1'b0;
    ram[int'(ad)] = dt;
  endtask

  task automatic exec_instr(input logic [W-1:0] word, input int wf, input int wm);
    logic [W-1:0] m, out, aold;
    logic [AW-1:0] tgt;
    bit rd, wr, tk, hlt;
    rd = word[W-1] && word[12];
    wr = word[W-1] && word[3];
    do_fetch(word, wf);
    if (!word[W-1]) begin
      a_m = {1'b0, word[W-2:0]}; pc_m = pc_m + 1; exp_dur = wf + 2; chain = 1;
      return;
    end
    m = '0;
    if (rd) begin
      if (!ram.exists(int'(a_m[AW-1:0]))) ram[int'(a_m[AW-1:0])] = W'($urandom);
      m = ram[int'(a_m[AW-1:0])];
      do_read(wm, m);
    end
    out = comp_val(word[11:6], d_m, rd ? m : a_m);
    tk = (word[2] && $signed(out) < 0) || (word[1] && out == 0) || (word[0] && $signed(out) > 0);
    aold = a_m; tgt = aold[AW-1:0];
    if (word[5]) a_m = out;
    if (word[4]) d_m = out;
    if (wr) do_write(wm, tgt, out);
    hlt = 0;
`ifdef HACK_CPU_HALT_DETECT_EN
    hlt = tk && (tgt == pc_m) && !wr;
`endif
    pc_m = tk ? tgt : pc_m + 1;
    exp_dur = wf + 2 + (rd ? wm + 1 : 0) + (wr ? wm + 1 : 0);
    chain = 1;
    if (hlt) begin
      repeat (3) @(negedge clock);
      chk("halt_flag", halted, 1); chk("halt_noreq", {instr_req, mem_re, mem_we}, 0);
      chk("halt_pc", pc, pc_m);    chk("halt_A", dut.a_q, a_m); chk("halt_D", dut.d_q, d_m);
      halted_m = 1; chain = 0;
    end
  endtask

  initial begin
    logic [W-1:0] w;
    rom32[0] = 32'h4000_0000;
    rom32[1] = {19'h7FFFF, 1'b0, C_A, 3'b010, 3'b000};
    rom32[2] = {19'h7FFFF, 1'b0, C_DPA, 3'b010, 3'b000};
    rom32[3] = 32'd10;
    rom32[4] = {19'h7FFFF, 1'b0, C_D, 3'b000, 3'b100};
    rom32[5] = 32'd0; rom32[6] = 32'd0; rom32[7] = 32'd0;

    // @5 ; D=A
    do_reset();
    exec_instr(16'd5, 0, 0);
    exec_instr(cw(0, C_A, 3'b010, 3'b000), 0, 0);
    wait_for(0, "sync");
    chk("DA_cycles", cyc - t_start, 4);
    chk("DA_D", dut.d_q, 5); chk("DA_A", dut.a_q, 5); chk("DA_pc", pc, 2);

    // @100 ; D=M with a 3-cycle read stall
    do_reset();
    ram[100] = 16'h1234;
    exec_instr(16'd100, 0, 0);
    exec_instr(cw(1, C_A, 3'b010, 3'b000), 1, 3);
    wait_for(0, "sync");
    chk("DM_D", dut.d_q, 16'h1234); chk("DM_pc", pc, 2);

    // D=5 ; @100 ; AM=D+1 stalled, then reset mid-stall
    do_reset();
    exec_instr(16'd5, 0, 0);
    exec_instr(cw(0, C_A, 3'b010, 3'b000), 0, 0);
    exec_instr(16'd100, 2, 0);
    do_fetch(cw(0, C_DP1, 3'b101, 3'b000), 0);
    wait_for(2, "AM_we");
    chk("AM_addr", mem_addr, 100); chk("AM_data", mem_wdata, 6);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("AM_stall", {mem_we, mem_addr, mem_wdata}, {1'b1, 15'd100, 16'd6});
    end
    chk("AM_A", dut.a_q, 6);
    do_reset();

    // Branches via @10
    exec_instr(16'd10, 0, 0);
    exec_instr(cw(0, C_ZERO, 3'b010, 3'b000), 0, 0);
    exec_instr(cw(0, C_D, 3'b000, 3'b010), 0, 0);
    wait_for(0, "sync"); chk("JEQ_pc", pc, 10);
    do_reset();
    exec_instr(16'd10, 0, 0);
    exec_instr(cw(0, C_ZERO, 3'b010, 3'b000), 0, 0);
    exec_instr(cw(0, C_D, 3'b000, 3'b001), 0, 0);
    wait_for(0, "sync"); chk("JGT_pc", pc, 3);
    do_reset();
    exec_instr(16'd10, 0, 0);
    exec_instr(cw(0, C_NEG1, 3'b010, 3'b000), 0, 0);
    chk("neg1_D_pending", dut.d_q, 0);
    exec_instr(cw(0, C_D, 3'b000, 3'b100), 0, 0);
    wait_for(0, "sync"); chk("JLT_pc", pc, 10); chk("JLT_D", dut.d_q, 16'hFFFF);

    // Self-loop 0;JMP at pc=3 with A=3
    do_reset();
    exec_instr(16'd3, 0, 0);
    exec_instr(cw(0, C_A, 3'b010, 3'b000), 0, 0);
    exec_instr(16'd3, 0, 0);
    exec_instr(cw(0, C_ZERO, 3'b000, 3'b111), 0, 0);
`ifdef HACK_CPU_HALT_DETECT_EN
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("halt_stay", {halted, instr_req}, 2'b10);
    end
`else
    exec_instr(cw(0, C_ZERO, 3'b000, 3'b111), 0, 0);
    exec_instr(cw(0, C_ZERO, 3'b000, 3'b111), 0, 0);
    wait_for(0, "sync");
    chk("loop_pc", pc, 3); chk("loop_cycles", cyc - t_prev, 2); chk("loop_halted", halted, 0);
`endif

    // Random programs with random wait states
    do_reset();
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        w = W'($urandom); w[W-1] = 1'b0;
      end else begin
        w = {1'b1, 2'($urandom), 1'($urandom), comps[$urandom_range(0, 17)], 3'($urandom), 3'($urandom)};
      end
      exec_instr(w, $urandom_range(0, 3), $urandom_range(0, 3));
      if (halted_m) do_reset();
    end

    // WIDTH=32: D=0x8000_0000 then D;JLT to 10
    r32 = 1'b0;
    repeat (10) @(negedge clock);
    chk("w32_req", ireq32, 1); chk("w32_addr", iaddr32, 10);
    chk("w32_D", dut32.d_q, 32'h8000_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
